// File: rtl/pcm_sample_feeder.sv
// PCM sample-rate buffer feeding the sigma-delta DAC: a small FIFO filled over valid/ready,
// drained one sample every SAMPLE_DIV clocks, with underrun hold and a sticky underrun flag.
module pcm_sample_feeder #(
  parameter int unsigned BITDEPTH        = 14,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned SAMPLE_DIV      = 256,
  parameter int unsigned SIGNED_IN       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [BITDEPTH-1:0]        wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [BITDEPTH-1:0]        pcm,
  output logic                       sample_tick,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       underrun,
  input  logic                       underrun_clr
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [BITDEPTH-1:0] MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};

  logic [BITDEPTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BITDEPTH-1:0] pcm_q, pcm_d;
  logic                tick_q, tick_d;
  logic                unr_q, unr_d;

  logic                full, empty, push, tick, pop;
  logic [BITDEPTH-1:0] wr_conv;

  // Signed input becomes offset binary by flipping the MSB before it is stored.
  assign wr_conv = (SIGNED_IN != 0) ? {~wr_data[BITDEPTH-1], wr_data[BITDEPTH-2:0]} : wr_data;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == LVL_W'(0));
  assign push  = wr_valid && !full;
  assign tick  = en && (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign pop   = tick && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    div_d    = div_q;
    pcm_d    = pcm_q;
    tick_d   = tick;
    unr_d    = unr_q;

    if (!en || tick) div_d = DIV_W'(0);
    else             div_d = div_q + DIV_W'(1);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      pcm_d    = mem_q[rd_ptr_q];
    end

    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    // A new underrun on the same edge as a clear keeps the flag set.
    if (tick && empty)     unr_d = 1'b1;
    else if (underrun_clr) unr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      div_q    <= '0;
      pcm_q    <= MIDSCALE;
      tick_q   <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      div_q    <= div_d;
      pcm_q    <= pcm_d;
      tick_q   <= tick_d;
      unr_q    <= unr_d;
    end
  end

  // Sample storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_conv;
  end

  assign wr_ready    = !full;
  assign pcm         = pcm_q;
  assign sample_tick = tick_q;
  assign fifo_level  = level_q;
  assign underrun    = unr_q;

endmodule

// File: tb/tb_pcm_sample_feeder.sv
// Self-checking bench: a queue-based reference model checked every cycle, plus directed
// checks of the reset, sequence, full, simultaneous, underrun and mid-stream reset cases.
module tb_pcm_sample_feeder;

  logic        clk = 1'b0;
  logic        rst, en, wr_valid, underrun_clr;
  logic [13:0] wr_data;
  logic        wr_ready, sample_tick, underrun;
  logic [13:0] pcm;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  pcm_sample_feeder dut (
    .clk(clk), .rst(rst), .en(en), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .pcm(pcm), .sample_tick(sample_tick), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] conv(input logic [13:0] d);
    return {~d[13], d[12:0]};
  endfunction

  function automatic logic [13:0] dval(input int i);
    return 14'(i * 'h2F3 + 'h11);
  endfunction

  // Reference model: scoreboard queue filled on accepted writes, drained on model ticks.
  logic [13:0] mq[$];
  int          m_div;
  logic [13:0] m_pcm;
  logic        m_tick, m_unr, m_valid = 1'b0;
  logic        m_t, m_emp, m_ful;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_div = 0; m_pcm = 14'h2000; m_tick = 1'b0; m_unr = 1'b0; m_valid = 1'b1;
    end else begin
      m_t   = en && (m_div == 255);
      m_emp = (mq.size() == 0);
      m_ful = (mq.size() == 16);
      if (m_t && !m_emp) m_pcm = mq.pop_front();
      if (wr_valid && !m_ful) mq.push_back(conv(wr_data));
      if (m_t && m_emp) m_unr = 1'b1;
      else if (underrun_clr) m_unr = 1'b0;
      m_tick = m_t;
      m_div  = (!en || m_t) ? 0 : m_div + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_tick", 32'(sample_tick), 32'(m_tick));
      check("m_pcm", 32'(pcm), 32'(m_pcm));
      check("m_level", 32'(fifo_level), 32'(mq.size()));
      check("m_ready", 32'(wr_ready), 32'(mq.size() != 16));
      check("m_underrun", 32'(underrun), 32'(m_unr));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sample_tick && cyc < 2000);
    if (!sample_tick) check("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic write(input logic [13:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  int cyc;

  initial begin
    rst = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_data = '0; underrun_clr = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset values and first (underrun) tick
    check("rst_pcm", 32'(pcm), 32'h2000);
    check("rst_ready", 32'(wr_ready), 32'(1));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    check("rst_tick", 32'(sample_tick), 32'(0));
    wait_tick(cyc);
    check("first_tick_cyc", 32'(cyc), 32'(256));
    check("first_tick_pcm", 32'(pcm), 32'h2000);
    check("first_tick_unr", 32'(underrun), 32'(1));

    // Clear on a non-tick cycle, then the signed sequence
    underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
    check("clr_unr", 32'(underrun), 32'(0));
    write(14'h0000); write(14'h1FFF); write(14'h2000);
    check("seq_level3", 32'(fifo_level), 32'(3));
    wait_tick(cyc);
    check("seq_pcm1", 32'(pcm), 32'h2000);
    check("seq_level2", 32'(fifo_level), 32'(2));
    wait_tick(cyc);
    check("seq_cyc2", 32'(cyc), 32'(256));
    check("seq_pcm2", 32'(pcm), 32'h3FFF);
    check("seq_level1", 32'(fifo_level), 32'(1));
    wait_tick(cyc);
    check("seq_pcm3", 32'(pcm), 32'h0000);
    check("seq_level0", 32'(fifo_level), 32'(0));
    check("seq_unr", 32'(underrun), 32'(0));

    // Underrun hold of the last sample, clear, and set-beats-clear
    write(14'h3234);
    wait_tick(cyc);
    check("unr_pcm_a", 32'(pcm), 32'h1234);
    wait_tick(cyc);
    check("unr_pcm_hold", 32'(pcm), 32'h1234);
    check("unr_set", 32'(underrun), 32'(1));
    underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
    check("unr_clr", 32'(underrun), 32'(0));
    underrun_clr = 1'b1;
    wait_tick(cyc);
    underrun_clr = 1'b0;
    check("unr_set_wins", 32'(underrun), 32'(1));
    underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;

    // Fill while halted: 17 writes, 16 accepted
    en = 1'b0;
    step(1);
    wr_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = dval(i);
      if (i == 16) begin
        check("full_ready", 32'(wr_ready), 32'(0));
        check("full_level", 32'(fifo_level), 32'(16));
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("full_level_after", 32'(fifo_level), 32'(16));
    step(3);
    check("halt_no_pop", 32'(fifo_level), 32'(16));

    // Drain in order; pop from full reopens wr_ready
    en = 1'b1;
    wait_tick(cyc);
    check("drain_cyc", 32'(cyc), 32'(256));
    check("drain_pcm0", 32'(pcm), 32'(conv(dval(0))));
    check("drain_level15", 32'(fifo_level), 32'(15));
    check("drain_ready", 32'(wr_ready), 32'(1));
    for (int k = 1; k <= 10; k++) begin
      wait_tick(cyc);
      check("drain_pcm", 32'(pcm), 32'(conv(dval(k))));
    end
    check("drain_level5", 32'(fifo_level), 32'(5));

    // Write landing on the tick edge at level 5
    step(255);
    wr_valid = 1'b1; wr_data = 14'h0ABC;
    step(1);
    wr_valid = 1'b0;
    check("simul_tick", 32'(sample_tick), 32'(1));
    check("simul_level", 32'(fifo_level), 32'(5));
    check("simul_pcm", 32'(pcm), 32'(conv(dval(11))));
    for (int k = 12; k <= 15; k++) begin
      wait_tick(cyc);
      check("tail_pcm", 32'(pcm), 32'(conv(dval(k))));
    end
    wait_tick(cyc);
    check("tail_written", 32'(pcm), 32'h2ABC);
    check("tail_level0", 32'(fifo_level), 32'(0));

    // Mid-stream reset flushes and restarts the divider phase
    for (int i = 0; i < 8; i++) write(dval(i + 40));
    check("mid_level8", 32'(fifo_level), 32'(8));
    step(100);
    rst = 1'b1; step(1); rst = 1'b0;
    check("mid_level0", 32'(fifo_level), 32'(0));
    check("mid_pcm", 32'(pcm), 32'h2000);
    check("mid_unr", 32'(underrun), 32'(0));
    check("mid_ready", 32'(wr_ready), 32'(1));
    wait_tick(cyc);
    check("mid_tick_cyc", 32'(cyc), 32'(256));
    check("mid_tick_pcm", 32'(pcm), 32'h2000);

    step(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
